// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter in front of a single-ported
// unified memory with registered read data and range checking.
module mem_arbiter #(
  parameter int unsigned DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        err,
  output logic [31:0] mem_pc_address,
  output logic [31:0] mem_alu_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we,
  output logic        mem_memread,
  output logic        mem_IorD,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DONE,
    WR_ISSUE,
    WR_DONE,
    ERR
  } state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH);

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_q;
  logic        we_q;
  logic [31:0] pc_addr_q;
  logic [31:0] alu_addr_q;
  logic [31:0] wdata_q;
  logic        gnt_if, gnt_d;

  // Under contention the side not recorded in last-grant wins.
  always_comb begin
    gnt_d  = d_req  & (~if_req | ~last_q);
    gnt_if = if_req & (~d_req  |  last_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d)
          state_d = (d_addr >= LIMIT) ? ERR : (d_we ? WR_ISSUE : RD_ISSUE);
        else if (gnt_if)
          state_d = (if_addr >= LIMIT) ? ERR : RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_DONE;
      RD_DONE:  state_d = IDLE;
      WR_ISSUE: state_d = WR_DONE;
      WR_DONE:  state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      pc_addr_q  <= '0;
      alu_addr_q <= '0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_d) begin
            owner_q    <= 1'b1;
            last_q     <= 1'b1;
            alu_addr_q <= d_addr;
            we_q       <= d_we;
            wdata_q    <= d_wdata;
          end else if (gnt_if) begin
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            pc_addr_q <= if_addr;
          end
        end
        RD_DONE: begin
          if (owner_q) begin
            d_rdata <= mem_data_out;
            d_valid <= 1'b1;
          end else begin
            if_rdata <= mem_data_out;
            if_valid <= 1'b1;
          end
        end
        WR_DONE: d_valid <= 1'b1;
        ERR: begin
          err <= 1'b1;
          if (owner_q) begin
            d_valid <= 1'b1;
            if (!we_q) d_rdata <= '0;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_memread     = (state_q == RD_ISSUE);
    mem_we          = (state_q == WR_ISSUE);
    mem_IorD        = owner_q;
    mem_pc_address  = pc_addr_q;
    mem_alu_address = alu_addr_q;
    mem_data_in     = wdata_q;
    busy            = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter: a registered-read memory
// plus a word-array reference model and latency/round-robin expectations.
module tb_mem_arbiter;
  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, d_valid, err;
  logic [31:0] mem_pc_address, mem_alu_address, mem_data_in, mem_data_out;
  logic        mem_we, mem_memread, mem_IorD, busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        overlap_seen = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .mem_pc_address(mem_pc_address), .mem_alu_address(mem_alu_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_we(mem_we), .mem_memread(mem_memread), .mem_IorD(mem_IorD), .busy(busy)
  );

  // Memory: registered read, data valid the cycle after memread.
  always @(posedge clk) begin
    if (mem_we && mem_alu_address < DEPTH) mem[mem_alu_address] <= mem_data_in;
    if (mem_memread) begin
      if (mem_IorD) mem_data_out <= (mem_alu_address < DEPTH) ? mem[mem_alu_address] : 'x;
      else          mem_data_out <= (mem_pc_address  < DEPTH) ? mem[mem_pc_address]  : 'x;
    end
  end

  always @(negedge clk) if (mem_we && mem_memread) overlap_seen = 1'b1;

  // Issues one request right after a rising edge and waits (bounded) for completion.
  task automatic drive_txn(input bit dside, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                           output logic e, output int n_we, output int n_rd,
                           output logic rd_first, output logic iord, output logic [31:0] we_addr,
                           output logic again, output logic busy_v);
    lat = -1; rd = 'x; e = 1'bx; n_we = 0; n_rd = 0; rd_first = 1'b0;
    iord = 1'bx; we_addr = 'x; again = 1'b0; busy_v = 1'bx;
    if (dside) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_memread) begin n_rd++; iord = mem_IorD; if (k == 1) rd_first = 1'b1; end
      if (mem_we) begin n_we++; we_addr = mem_alu_address; end
      if (dside ? d_valid : if_valid) begin
        lat = k; rd = dside ? d_rdata : if_rdata; e = err; busy_v = busy;
        break;
      end
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
    again = (dside ? d_valid : if_valid) | err;
  endtask

  int          lat, n_we, n_rd;
  logic [31:0] rd, we_addr;
  logic        e, rd_first, iord, again, busy_v;

  task automatic test_reset();
    if ({if_rdata, d_rdata, if_valid, d_valid, err, mem_pc_address, mem_alu_address,
         mem_data_in, mem_we, mem_memread, mem_IorD, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero (busy=%b rd=%b we=%b)", busy, mem_memread, mem_we);
    end
    checks++;
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_fetch_read();
    drive_txn(0, 0, 32'd0, 32'd0, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
    checks++;
    if (rd_first !== 1'b1 || iord !== 1'b0) begin
      errors++; $display("FAIL fetch_issue: memread_first=%b IorD=%b required 1/0", rd_first, iord);
    end
    checks++;
    if (lat !== 3 || rd !== 32'h00221800) begin
      errors++; $display("FAIL fetch_result: lat=%0d rdata=%h required 3/00221800", lat, rd);
    end
    checks++;
    if (again !== 1'b0) begin errors++; $display("FAIL fetch_pulse: valid stayed high"); end
  endtask

  task automatic test_store_load();
    drive_txn(1, 1, 32'd5, 32'hDEADBEEF, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
    ref_mem[5] = 32'hDEADBEEF;
    checks++;
    if (n_we !== 1 || we_addr !== 32'd5 || n_rd !== 0) begin
      errors++; $display("FAIL store_enables: we_cycles=%0d addr=%0d rd_cycles=%0d required 1/5/0", n_we, we_addr, n_rd);
    end
    checks++;
    if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL store_done: lat=%0d err=%b required 3/0", lat, e); end
    drive_txn(1, 0, 32'd5, 32'd0, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
    checks++;
    if (rd !== ref_mem[5] || iord !== 1'b1 || lat !== 3) begin
      errors++; $display("FAIL load_back: rdata=%h IorD=%b lat=%0d required %h/1/3", rd, iord, lat, ref_mem[5]);
    end
  endtask

  task automatic test_out_of_range();
    drive_txn(1, 0, 32'd10, 32'd0, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
    checks++;
    if (n_we + n_rd !== 0) begin errors++; $display("FAIL oor_enables: enable cycles=%0d required 0", n_we + n_rd); end
    checks++;
    if (lat !== 2 || e !== 1'b1 || rd !== 32'd0 || busy_v !== 1'b0) begin
      errors++; $display("FAIL oor_result: lat=%0d err=%b rdata=%h busy=%b required 2/1/0/0", lat, e, rd, busy_v);
    end
    checks++;
    if (again !== 1'b0) begin errors++; $display("FAIL oor_pulse: valid/err stayed high"); end
  endtask

  task automatic test_contention();
    int got[$];
    int when[$];
    bit last = 1'b1;
    bit g;
    rst = 0;
    if_req = 1; if_addr = 32'd3;
    d_req = 1; d_we = 0; d_addr = 32'd7;
    @(negedge clk) rst = 1;
    for (int k = 1; k <= 40 && got.size() < 4; k++) begin
      @(posedge clk); #1;
      if (if_valid) begin
        got.push_back(0); when.push_back(k);
        checks++;
        if (if_rdata !== ref_mem[3]) begin errors++; $display("FAIL cont_if_data: %h required %h", if_rdata, ref_mem[3]); end
      end
      if (d_valid) begin
        got.push_back(1); when.push_back(k);
        checks++;
        if (d_rdata !== ref_mem[7]) begin errors++; $display("FAIL cont_d_data: %h required %h", d_rdata, ref_mem[7]); end
      end
    end
    if_req = 0; d_req = 0;
    checks++;
    if (got.size() !== 4) begin errors++; $display("FAIL cont_count: pulses=%0d required 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      g = ~last; last = g;
      checks++;
      if (got[i] !== int'(g) || when[i] !== 3 * (i + 1)) begin
        errors++; $display("FAIL cont_order[%0d]: side=%0d cycle=%0d required %0d/%0d", i, got[i], when[i], g, 3 * (i + 1));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (overlap_seen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_exclusive: overlap=%b busy=%b required 0/0", overlap_seen, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    if_req = 1; if_addr = 32'd2;
    @(posedge clk); #2;
    checks++;
    if (mem_memread !== 1'b1) begin errors++; $display("FAIL midrst_pre: memread=%b required 1", mem_memread); end
    rst = 0;
    #1;
    checks++;
    if (mem_memread !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async: memread=%b busy=%b required 0/0", mem_memread, busy);
    end
    if_req = 0;
    @(negedge clk) rst = 1;
    repeat (6) begin @(posedge clk); #1; if (if_valid) stray = 1; end
    checks++;
    if (stray) begin errors++; $display("FAIL midrst_stray: if_valid=1 after release required 0"); end
    drive_txn(0, 0, 32'd2, 32'd0, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
    checks++;
    if (lat !== 3 || rd !== ref_mem[2]) begin
      errors++; $display("FAIL midrst_reissue: lat=%0d rdata=%h required 3/%h", lat, rd, ref_mem[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_drd = '0;  // d_rdata was cleared by the preceding reset
    logic [31:0] exp_rd;
    for (int t = 0; t < 30; t++) begin
      bit dside = 1'($urandom % 2);
      bit we = dside & 1'($urandom % 2);
      logic [31:0] a = $urandom_range(0, 12);
      logic [31:0] wd = $urandom;
      bit inr = (a < DEPTH);
      drive_txn(dside, we, a, wd, lat, rd, e, n_we, n_rd, rd_first, iord, we_addr, again, busy_v);
      if (we) exp_rd = exp_drd;
      else    exp_rd = inr ? ref_mem[a] : 32'd0;
      if (we && inr) ref_mem[a] = wd;
      if (dside) exp_drd = exp_rd;
      checks++;
      if (lat !== (inr ? 3 : 2) || e !== !inr) begin
        errors++; $display("FAIL rand_timing[%0d]: lat=%0d err=%b required %0d/%b", t, lat, e, inr ? 3 : 2, !inr);
      end
      checks++;
      if (rd !== exp_rd || n_we !== int'(we && inr) || n_rd !== int'(!we && inr)) begin
        errors++; $display("FAIL rand_data[%0d]: rdata=%h we=%0d rd=%0d required %h/%0d/%0d",
                           t, rd, n_we, n_rd, exp_rd, int'(we && inr), int'(!we && inr));
      end
      checks++;
      if (again !== 1'b0) begin errors++; $display("FAIL rand_pulse[%0d]: valid/err stayed high", t); end
    end
    checks++;
    if (overlap_seen !== 1'b0) begin errors++; $display("FAIL rand_exclusive: memread and we overlapped"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = (i == 0) ? 32'h00221800 : $urandom;
      mem[i] = ref_mem[i];
    end
    mem_data_out = '0;
    rst = 0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_out_of_range();
    test_contention();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
